// File: rtl/master_pkg.sv
// ---------------------------------------------------------------------------
// master_pkg
// Shared types and constants for the master_unit register-file/ALU datapath.
//   - op_e   : 4-bit op-code enumeration (16 operations)
//   - ins_t  : instruction word layout {op, Rx, Ry, Rz}
//   - DATA_W / REG_ADDR_W / NUM_REGS and instruction field slice positions
// ---------------------------------------------------------------------------
package master_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 4;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;
    localparam int INS_W      = 16;

    // Instruction field slices
    localparam int OP_MSB = 15;
    localparam int OP_LSB = 12;
    localparam int RX_MSB = 11;
    localparam int RX_LSB = 8;
    localparam int RY_MSB = 7;
    localparam int RY_LSB = 4;
    localparam int RZ_MSB = 3;
    localparam int RZ_LSB = 0;

    typedef enum logic [3:0] {
        OP_ADD   = 4'h0,
        OP_SUB   = 4'h1,
        OP_AND   = 4'h2,
        OP_OR    = 4'h3,
        OP_XOR   = 4'h4,
        OP_NOR   = 4'h5,
        OP_SLL   = 4'h6,
        OP_SRL   = 4'h7,
        OP_SRA   = 4'h8,
        OP_INC   = 4'h9,
        OP_DEC   = 4'hA,
        OP_NOT   = 4'hB,
        OP_SLT   = 4'hC,
        OP_MOV   = 4'hD,
        OP_SWAPB = 4'hE,
        OP_NOP   = 4'hF
    } op_e;

    typedef struct packed {
        op_e                   op;
        logic [REG_ADDR_W-1:0] rx;
        logic [REG_ADDR_W-1:0] ry;
        logic [REG_ADDR_W-1:0] rz;
    } ins_t;

    function automatic ins_t decode_ins(input logic [INS_W-1:0] w);
        ins_t d;
        d.op = op_e'(w[OP_MSB:OP_LSB]);
        d.rx = w[RX_MSB:RX_LSB];
        d.ry = w[RY_MSB:RY_LSB];
        d.rz = w[RZ_MSB:RZ_LSB];
        return d;
    endfunction

endpackage

// File: rtl/master_alu.sv
// ---------------------------------------------------------------------------
// master_alu
// Purely combinational ALU for master_unit. All results wrap modulo 2^16.
// Ports:
//   op_i  : operation (op_e)
//   a_i   : operand A (R[Rx])
//   b_i   : operand B (R[Ry]); shifts use only b_i[3:0]
//   res_o : result
//   we_o  : register/display write enable, low only for NOP
// ---------------------------------------------------------------------------
module master_alu
    import master_pkg::*;
(
    input  op_e               op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] res_o,
    output logic              we_o
);

    logic [3:0] shamt;
    assign shamt = b_i[3:0];

    always_comb begin
        res_o = '0;
        we_o  = 1'b1;
        case (op_i)
            OP_ADD:   res_o = a_i + b_i;
            OP_SUB:   res_o = a_i - b_i;
            OP_AND:   res_o = a_i & b_i;
            OP_OR:    res_o = a_i | b_i;
            OP_XOR:   res_o = a_i ^ b_i;
            OP_NOR:   res_o = ~(a_i | b_i);
            OP_SLL:   res_o = a_i << shamt;
            OP_SRL:   res_o = a_i >> shamt;
            OP_SRA:   res_o = DATA_W'($signed(a_i) >>> shamt);
            OP_INC:   res_o = a_i + DATA_W'(1);
            OP_DEC:   res_o = a_i - DATA_W'(1);
            OP_NOT:   res_o = ~a_i;
            OP_SLT:   res_o = DATA_W'($signed(a_i) < $signed(b_i));
            OP_MOV:   res_o = a_i;
            OP_SWAPB: res_o = {a_i[7:0], a_i[15:8]};
            OP_NOP:   we_o  = 1'b0;
            default:  we_o  = 1'b0;
        endcase
    end

endmodule

// File: rtl/master_unit.sv
// ---------------------------------------------------------------------------
// master_unit
// Register-file/ALU execution unit. A clock-enable divider produces one
// execution tick every CLK_DIV boardclk cycles; on each tick the instruction
// Rz <= Rx op Ry executes and the result is registered onto disp.
// Parameters:
//   CLK_DIV  : boardclk cycles per execution tick (2 .. 2^24)
// Ports:
//   boardclk : system clock, rising edge
//   rst      : synchronous active-high reset
//   ins      : instruction {op[15:12], Rx[11:8], Ry[7:4], Rz[3:0]}
//   enable   : one-cycle execution tick
//   disp     : result of the last executed (non-NOP) instruction
// Build option:
//   ZERO_REG_EN : when defined, R0 reads as zero and writes to it are
//                 dropped (disp still shows the result).
// ---------------------------------------------------------------------------
module master_unit
    import master_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic              boardclk,
    input  logic              rst,
    input  logic [INS_W-1:0]  ins,
    output logic              enable,
    output logic [DATA_W-1:0] disp
);

    localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic [NUM_REGS-1:0][DATA_W-1:0]  regs_q, regs_d;
    logic [DATA_W-1:0]                disp_q, disp_d;

    ins_t              ins_s;
    logic [DATA_W-1:0] op_a, op_b, alu_res;
    logic              alu_we, wr_reg;

    // Tick decoded from the registered count so it is glitch-free.
    assign enable = (cnt_q == CNT_LAST);
    assign cnt_d  = enable ? '0 : cnt_q + CNT_W'(1);

    assign ins_s = decode_ins(ins);

    // Operand reads see pre-edge register contents, so Rz==Rx/Ry uses
    // the old value.
`ifdef ZERO_REG_EN
    assign op_a   = (ins_s.rx == '0) ? '0 : regs_q[ins_s.rx];
    assign op_b   = (ins_s.ry == '0) ? '0 : regs_q[ins_s.ry];
    assign wr_reg = enable && alu_we && (ins_s.rz != '0);
`else
    assign op_a   = regs_q[ins_s.rx];
    assign op_b   = regs_q[ins_s.ry];
    assign wr_reg = enable && alu_we;
`endif

    master_alu u_alu (
        .op_i  (ins_s.op),
        .a_i   (op_a),
        .b_i   (op_b),
        .res_o (alu_res),
        .we_o  (alu_we)
    );

    always_comb begin
        regs_d = regs_q;
        if (wr_reg) begin
            regs_d[ins_s.rz] = alu_res;
        end
    end

    // disp follows every non-NOP tick, including R0 writes in the
    // zero-register build.
    assign disp_d = (enable && alu_we) ? alu_res : disp_q;

    always_ff @(posedge boardclk) begin
        if (rst) begin
            cnt_q  <= '0;
            disp_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= DATA_W'(i);
            end
        end else begin
            cnt_q  <= cnt_d;
            disp_q <= disp_d;
            regs_q <= regs_d;
        end
    end

    assign disp = disp_q;

endmodule

// File: tb/tb_master_unit.sv
module tb_master_unit;
    import master_pkg::*;

    localparam int unsigned CLK_DIV = 4;

    logic        boardclk = 1'b0;
    logic        rst;
    logic [15:0] ins;
    logic        enable;
    logic [15:0] disp;

    int checks   = 0;
    int failures = 0;

    master_unit #(.CLK_DIV(CLK_DIV)) dut (
        .boardclk (boardclk),
        .rst      (rst),
        .ins      (ins),
        .enable   (enable),
        .disp     (disp)
    );

    always #5 boardclk = ~boardclk;

    typedef struct {
        logic [15:0] ins;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Called at a negedge. Scrambles ins until the tick is seen (ins must be
    // ignored off-tick), presents the real instruction, lets the tick edge
    // pass, then checks disp. Returns the number of negedges waited.
    task automatic run_ins(input logic [15:0] i, input logic [15:0] exp,
                           input string nm, output int waited);
        int n = 0;
        while (!enable && n < 4 * CLK_DIV) begin
            ins = 16'($urandom);
            @(negedge boardclk);
            n++;
        end
        waited = n;
        if (!enable) begin
            check({nm, "_tick_timeout"}, 32'(enable), 32'd1);
        end else begin
            ins = i;
            @(negedge boardclk);
            check(nm, 32'(disp), 32'(exp));
        end
    endtask

    // Reset asserted for ncyc rising edges, released at a negedge.
    task automatic do_reset(input int ncyc);
        rst = 1'b1;
        repeat (ncyc) @(negedge boardclk);
        rst = 1'b0;
    endtask

    // Count rising edges after reset release until enable is seen.
    task automatic edges_to_tick(output int n);
        n = 0;
        while (!enable && n < 4 * CLK_DIV) begin
            @(negedge boardclk);
            n++;
        end
    endtask

    initial begin
        int w;
        rst = 1'b1;
        ins = 16'hF000;

        // Reset hold 3 cycles: state must stay in reset.
        for (int k = 0; k < 3; k++) begin
            @(negedge boardclk);
            check("rst_disp", 32'(disp), 32'd0);
            check("rst_enable", 32'(enable), 32'd0);
        end
        rst = 1'b0;

        // First tick lands in the CLK_DIV-th cycle after release.
        edges_to_tick(w);
        check("first_tick_latency", 32'(w), 32'(CLK_DIV - 1));
        @(negedge boardclk);
        check("enable_one_cycle", 32'(enable), 32'd0);

        // SRL R1,R15 -> R1 held: 1>>15 = 0, then 0 stays 0.
        do_reset(1);
        run_ins(16'h71F1, 16'h0000, "srl_first", w);
        run_ins(16'h71F1, 16'h0000, "srl_again", w);
        check("tick_period", 32'(w + 1), 32'(CLK_DIV));

        // Main table, starting from reset contents R[i]=i.
        do_reset(1);
        vecs = '{
            '{16'h0234, 16'h0005, "add_r2_r3"},
            '{16'h0444, 16'h000A, "add_acc1"},
            '{16'h0444, 16'h0014, "add_acc2"},
            '{16'h1015, 16'hFFFF, "sub_wrap"},
            '{16'h8516, 16'hFFFF, "sra_neg"},
            '{16'h75F7, 16'h0001, "srl_15"},
            '{16'hC518, 16'h0001, "slt_neg_lt"},
            '{16'hC158, 16'h0000, "slt_rev"},
            '{16'h2469, 16'h0014, "and"},
            '{16'h323A, 16'h0003, "or"},
            '{16'h43AB, 16'h0000, "xor_self"},
            '{16'h500C, 16'hFFFF, "nor_zero"},
            '{16'h63FD, 16'h8000, "sll_15"},
            '{16'h9D0E, 16'h8001, "inc"},
            '{16'hA00F, 16'hFFFF, "dec_wrap"},
            '{16'hB30A, 16'hFFFC, "not"},
            '{16'hDE0B, 16'h8001, "mov"},
            '{16'hEE0C, 16'h0180, "swapb"},
            '{16'hF000, 16'h0180, "nop_hold"},
            '{16'hDC01, 16'h0180, "nop_r12_kept"},
            '{16'hD002, 16'h0000, "nop_r0_kept"},
            '{16'hD901, 16'h0014, "r9_before_rst"}
        };
        for (int k = 0; k < vecs.size(); k++) begin
            run_ins(vecs[k].ins, vecs[k].exp, vecs[k].name, w);
            if (k > 0) check({vecs[k].name, "_period"}, 32'(w + 1), 32'(CLK_DIV));
        end

        // Reset asserted exactly on a tick edge: reset wins, no write.
        edges_to_tick(w);
        ins = 16'h0999;
        rst = 1'b1;
        @(negedge boardclk);
        check("rst_on_tick_disp", 32'(disp), 32'd0);
        check("rst_on_tick_enable", 32'(enable), 32'd0);
        rst = 1'b0;
        edges_to_tick(w);
        check("rst_on_tick_restart", 32'(w), 32'(CLK_DIV - 1));
        ins = 16'hD901;  // MOV R9 -> R1: R9 back to reset value 9
        @(negedge boardclk);
        check("rst_regs_restored", 32'(disp), 32'd9);

        // Mid-period reset discards the partial count.
        @(negedge boardclk);
        @(negedge boardclk);
        do_reset(1);
        edges_to_tick(w);
        check("rst_mid_restart", 32'(w), 32'(CLK_DIV - 1));

        // R0 as destination: the two builds diverge here.
        do_reset(1);
        run_ins(16'hD700, 16'h0007, "mov_r7_r0", w);
`ifdef ZERO_REG_EN
        run_ins(16'h0001, 16'h0000, "add_r0_r0", w);
`else
        run_ins(16'h0001, 16'h000E, "add_r0_r0", w);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
